// File: rtl/grey_capture_ctrl_pkg.sv
// Shared definitions for the grey frame-capture path: FSM encoding and the
// default frame geometry also used by the frame-buffer and recognition blocks.
package grey_capture_ctrl_pkg;

    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int DEF_ADDR_W = 19;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/grey_capture_ctrl_sync_edge_det.sv
// Registered copy of a stream control signal plus single-cycle rise/fall
// pulses, comparing the live input against its previous-cycle value.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_q <= 1'b0;
        else       r_q <= i_sig;
    end

    assign o_q    = r_q;
    assign o_rise = i_sig & ~r_q;
    assign o_fall = ~i_sig & r_q;

endmodule

// File: rtl/grey_capture_ctrl.sv
// Frame-capture sequencer: on request, waits for the next frame start and
// writes one grey frame into the buffer in raster order, flagging malformed frames.
module grey_capture_ctrl
    import grey_capture_ctrl_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_href,
    input  logic              in_vsync,
    input  logic              in_clken,
    input  logic [7:0]        in_grey,
    input  logic              cap_req,
    input  logic              cap_abort,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              frame_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    // One spare bit so overrun pixels/lines keep counting past the nominal size.
    localparam int COL_W = $clog2(IMG_W + 1) + 1;
    localparam int ROW_W = $clog2(IMG_H + 1) + 1;
    localparam logic [COL_W-1:0] COL_FULL = COL_W'(IMG_W);
    localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(IMG_H);

    state_t             r_state;
    state_t             w_state_next;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_frame_err;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [7:0]         r_wr_data;

    logic w_vsync_q, w_vsync_rise, w_vsync_fall;
    logic w_href_q, w_href_rise, w_href_fall;
    logic w_sof, w_eof, w_eol;
    logic w_start, w_in_cap, w_accept, w_overrun, w_write, w_err_set;
    logic [ROW_W-1:0] w_row_eol;
    logic w_unused;

    sync_edge_det u_vsync_det (
        .clk    (clk),
        .reset  (reset),
        .i_sig  (in_vsync),
        .o_q    (w_vsync_q),
        .o_rise (w_vsync_rise),
        .o_fall (w_vsync_fall)
    );

    sync_edge_det u_href_det (
        .clk    (clk),
        .reset  (reset),
        .i_sig  (in_href),
        .o_q    (w_href_q),
        .o_rise (w_href_rise),
        .o_fall (w_href_fall)
    );

    assign w_unused = ^{w_vsync_q, w_href_q, w_href_rise};

    assign w_sof = w_vsync_fall;
    assign w_eof = w_vsync_rise;
    assign w_eol = w_href_fall;

    assign w_start   = (r_state == ST_IDLE) && cap_req;
    assign w_in_cap  = (r_state == ST_CAPTURE) && !cap_abort;
    assign w_accept  = w_in_cap && in_href && in_clken;
    assign w_overrun = (r_col >= COL_FULL) || (r_row >= ROW_FULL);
    assign w_write   = w_accept && !w_overrun;

    // Row update from a coincident EOL must land before the EOF row check.
    assign w_row_eol = (w_eol && (r_col != '0) && (r_row != '1)) ? r_row + ROW_W'(1) : r_row;
    assign w_err_set = (w_accept && w_overrun)
                     | (w_eol && (r_col != COL_FULL))
                     | (w_eof && (w_row_eol != ROW_FULL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (cap_req) w_state_next = ST_WAIT_SOF;
            ST_WAIT_SOF: if (cap_abort) w_state_next = ST_IDLE;
                         else if (w_sof) w_state_next = ST_CAPTURE;
            ST_CAPTURE:  if (cap_abort) w_state_next = ST_IDLE;
                         else if (w_eof) w_state_next = ST_DONE;
            ST_DONE:     w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cap_busy = (r_state == ST_WAIT_SOF) || (r_state == ST_CAPTURE);
        cap_done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col       <= '0;
            r_row       <= '0;
            r_addr      <= '0;
            r_frame_err <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_addr <= r_addr;
                r_wr_data <= in_grey;
                r_addr    <= r_addr + ADDR_W'(1);
            end
            if (w_start) begin
                r_col       <= '0;
                r_row       <= '0;
                r_addr      <= '0;
                r_frame_err <= 1'b0;
            end else if (w_in_cap) begin
                if (w_eol)
                    r_col <= '0;
                else if (w_accept && (r_col != '1))
                    r_col <= r_col + COL_W'(1);
                r_row       <= w_row_eol;
                r_frame_err <= r_frame_err | w_err_set;
            end
        end
    end

    assign frame_err = r_frame_err;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_grey_capture_ctrl.sv
// Directed bench for grey_capture_ctrl on a 4x3 frame: clean capture, mid-frame
// request, overlong line, short frame, abort and asynchronous reset.
module tb_grey_capture_ctrl;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic              in_href, in_vsync, in_clken;
    logic [7:0]        in_grey;
    logic              cap_req, cap_abort;
    logic              cap_busy, cap_done, frame_err, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int eof_cyc  = 0;

    logic [ADDR_W-1:0] wa_q[$];
    logic [7:0]        wd_q[$];
    logic [ADDR_W-1:0] ea_q[$];
    logic [7:0]        ed_q[$];
    int                done_cnt = 0;
    int                done_cyc = 0;
    logic              done_err = 1'b0;

    grey_capture_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_href   (in_href),
        .in_vsync  (in_vsync),
        .in_clken  (in_clken),
        .in_grey   (in_grey),
        .cap_req   (cap_req),
        .cap_abort (cap_abort),
        .cap_busy  (cap_busy),
        .cap_done  (cap_done),
        .frame_err (frame_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Outputs are all registered or state-decoded, so sampling on the falling edge is stable.
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (cap_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = frame_err;
        end
    end

    task automatic drv(input logic h, input logic v, input logic ck, input logic [7:0] g,
                       input logic req, input logic ab);
        @(negedge clk);
        in_href = h; in_vsync = v; in_clken = ck; in_grey = g;
        cap_req = req; cap_abort = ab;
    endtask

    task automatic clear_obs();
        wa_q.delete(); wd_q.delete(); ea_q.delete(); ed_q.delete();
        done_cnt = 0;
    endtask

    // Plays one frame; live=1 means the pixels are expected in the buffer.
    task automatic run_frame(input int n_lines, input int long_line, input int req_line,
                             input int abort_px, input logic live_in);
        int   px, col_m;
        logic live;
        logic [7:0] g;
        g = 8'd0; px = 0; live = live_in;
        drv(0, 1, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        for (int l = 0; l < n_lines; l++) begin
            if (l == req_line) drv(0, 0, 0, 0, 1, 0);
            col_m = 0;
            for (int p = 0; p < ((l == long_line) ? 5 : 4); p++) begin
                drv(1, 0, 1, g, 0, 0);
                if (live && col_m < IMG_W && l < IMG_H) begin
                    ea_q.push_back(ADDR_W'(l * IMG_W + col_m));
                    ed_q.push_back(g);
                end
                col_m++; g++; px++;
                if (px == abort_px) begin
                    drv(1, 0, 0, 0, 0, 1);
                    live = 1'b0;
                end
            end
            drv(0, 0, 0, 0, 0, 0);
            drv(0, 0, 0, 0, 0, 0);
        end
        drv(0, 1, 0, 0, 0, 0);
        eof_cyc = cyc;
        drv(0, 1, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({wr_en, cap_busy, cap_done, frame_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got en/busy/done/err=%b, expected 0000",
                     {wr_en, cap_busy, cap_done, frame_err});
        end
        n_checks++;
        if ({wr_addr, wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_addr_data: got addr=%0d data=%0d, expected 0", wr_addr, wr_data);
        end
    endtask

    task automatic test_clean_frame();
        clear_obs();
        drv(0, 1, 0, 0, 1, 0);
        drv(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (cap_busy !== 1'b1) begin
            n_fail++; $display("FAIL clean_busy: got %b, expected 1", cap_busy);
        end
        run_frame(3, -1, -1, -1, 1'b1);
        n_checks++;
        if (wa_q.size() != 12) begin
            n_fail++; $display("FAIL clean_count: got %0d writes, expected 12", wa_q.size());
        end
        for (int i = 0; i < 12 && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== 8'(i)) begin
                n_fail++;
                $display("FAIL clean_write[%0d]: got addr=%0d data=%0d, expected %0d/%0d",
                         i, wa_q[i], wd_q[i], i, i);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != eof_cyc + 1) begin
            n_fail++;
            $display("FAIL clean_done: got %0d pulses at cycle %0d, expected 1 at %0d",
                     done_cnt, done_cyc, eof_cyc + 1);
        end
        n_checks++;
        if (done_err !== 1'b0 || cap_busy !== 1'b0) begin
            n_fail++; $display("FAIL clean_err_busy: got err=%b busy=%b, expected 0/0", done_err, cap_busy);
        end
    endtask

    // Compares observed writes against the bench's own expected queue.
    task automatic test_mid_frame_req();
        clear_obs();
        run_frame(3, -1, 1, -1, 1'b0);
        n_checks++;
        if (wa_q.size() != 0 || cap_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreq_first: got %0d writes busy=%b, expected 0 writes busy=1", wa_q.size(), cap_busy);
        end
        run_frame(3, -1, -1, -1, 1'b1);
        n_checks++;
        if (wa_q.size() != ea_q.size() || done_cnt != 1 || done_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreq_second: got %0d writes %0d done err=%b, expected %0d/1/0",
                     wa_q.size(), done_cnt, done_err, ea_q.size());
        end
        for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin
                n_fail++;
                $display("FAIL midreq_write[%0d]: got %0d/%0d, expected %0d/%0d",
                         i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]);
            end
        end
    endtask

    task automatic test_long_line();
        clear_obs();
        drv(0, 1, 0, 0, 1, 0);
        run_frame(3, 1, -1, -1, 1'b1);
        n_checks++;
        if (wa_q.size() != 12 || done_cnt != 1 || done_err !== 1'b1) begin
            n_fail++;
            $display("FAIL long_line: got %0d writes %0d done err=%b, expected 12/1/1",
                     wa_q.size(), done_cnt, done_err);
        end
        for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin
                n_fail++;
                $display("FAIL long_write[%0d]: got %0d/%0d, expected %0d/%0d",
                         i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        clear_obs();
        drv(0, 1, 0, 0, 1, 0);
        run_frame(2, -1, -1, -1, 1'b1);
        n_checks++;
        if (wa_q.size() != 8 || done_cnt != 1 || done_err !== 1'b1) begin
            n_fail++;
            $display("FAIL short_frame: got %0d writes %0d done err=%b, expected 8/1/1",
                     wa_q.size(), done_cnt, done_err);
        end
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++; $display("FAIL short_err_hold: got %b, expected 1", frame_err);
        end
    endtask

    task automatic test_abort();
        clear_obs();
        drv(0, 1, 0, 0, 1, 0);
        run_frame(3, -1, -1, 6, 1'b1);
        n_checks++;
        if (wa_q.size() != 6 || done_cnt != 0 || cap_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: got %0d writes %0d done busy=%b, expected 6/0/0",
                     wa_q.size(), done_cnt, cap_busy);
        end
        for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin
                n_fail++;
                $display("FAIL abort_write[%0d]: got %0d/%0d, expected %0d/%0d",
                         i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]);
            end
        end
        clear_obs();
        drv(0, 1, 0, 0, 1, 0);
        run_frame(3, -1, -1, -1, 1'b1);
        n_checks++;
        if (wa_q.size() != 12 || done_cnt != 1 || done_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_recapture: got %0d writes %0d done err=%b, expected 12/1/0",
                     wa_q.size(), done_cnt, done_err);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] g;
        clear_obs();
        g = 8'd0;
        drv(0, 1, 0, 0, 1, 0);
        drv(0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 5; p++) begin
            drv(1, 0, 1, g, 0, 0);
            g++;
        end
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 8'hAA, 0, 0);
        @(posedge clk);
        #2;
        n_checks++;
        if ({wr_en, cap_busy, frame_err} !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_pre: got en/busy/err=%b, expected 111", {wr_en, cap_busy, frame_err});
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({wr_en, cap_busy, cap_done, frame_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async: got en/busy/done/err=%b, expected 0000",
                     {wr_en, cap_busy, cap_done, frame_err});
        end
        drv(0, 1, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0);
        reset = 1'b0;
        clear_obs();
        run_frame(3, -1, -1, -1, 1'b0);
        n_checks++;
        if (wa_q.size() != 0 || done_cnt != 0 || cap_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: got %0d writes %0d done busy=%b, expected 0/0/0",
                     wa_q.size(), done_cnt, cap_busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_href = 1'b0; in_vsync = 1'b1; in_clken = 1'b0; in_grey = 8'd0;
        cap_req = 1'b0; cap_abort = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        drv(0, 1, 0, 0, 0, 0);
        test_clean_frame();
        test_mid_frame_req();
        test_long_line();
        test_short_frame();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grey_capture_ctrl.md
Name: grey_capture_ctrl

Overview:
Frame-capture sequencer between the RGB-to-grey pipeline output and the grey frame buffer.
- On a capture request, waits for the next frame start, then writes exactly one frame of grey pixels into the buffer in raster order.
- Raises done with an error flag, which the recognition engine consumes before starting.
- Rejects partial frames and malformed line/row counts.

Parameters:
IMG_W, 640, active pixels per line
IMG_H, 480, active lines per frame
ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous active-high reset
in_href  in  1  line valid from grey pipeline
in_vsync  in  1  frame sync from grey pipeline; high = vertical blanking
in_clken  in  1  pixel-valid strobe from grey pipeline
in_grey  in  8  grey pixel
cap_req  in  1  level request; sampled only in IDLE
cap_abort  in  1  abandon the capture in progress
cap_busy  out  1  high in WAIT_SOF and CAPTURE
cap_done  out  1  one-cycle pulse at end of capture
frame_err  out  1  valid with cap_done; held until next capture starts
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  frame-buffer write address
wr_data  out  8  frame-buffer write data

Behaviour:
Reset values: all outputs 0, state IDLE, all counters 0. Reset is asynchronous and active-high.

Edge detection and state:
- Registered copies of in_vsync and in_href are used for edge detection.
- SOF = vsync falling edge. EOF = vsync rising edge. EOL = href falling edge.
- States: IDLE, WAIT_SOF, CAPTURE, DONE.
- IDLE: cap_req=1 -> WAIT_SOF. On that transition, clear frame_err and all counters.
- WAIT_SOF: SOF -> CAPTURE. A request arriving mid-frame therefore waits for the next full frame.
- CAPTURE: EOF -> DONE.
- DONE: lasts one cycle; cap_done=1; then -> IDLE.
- cap_abort=1 in WAIT_SOF or CAPTURE -> IDLE with no cap_done. In IDLE or DONE, cap_abort has no effect.

Pixel writes:
- A pixel is accepted when state=CAPTURE and in_href=1 and in_clken=1.
- Write latency is 1 cycle: wr_en, wr_addr and wr_data are registered from the accepting cycle.
- wr_addr = row*IMG_W + col. It is kept as a running address that increments per accepted write, not computed with a multiplier.

Counters:
- col counts accepted pixels in the current line.
- On EOL: if col>0, row increments. If col != IMG_W, frame_err is set. col is cleared.
- Overrun pixel: col >= IMG_W or row >= IMG_H -> not written (wr_en stays 0), frame_err set. col still counts so the EOL check still fires.
- EOF: if row != IMG_H, frame_err is set. The frame_err value at cap_done therefore reflects the whole frame.

Simultaneous events:
- SOF and cap_req in the same IDLE cycle: request is taken (IDLE -> WAIT_SOF); that SOF is not used. Capture starts on the following SOF.
- EOF and cap_abort in the same cycle: abort wins, no cap_done.
- EOL and EOF in the same cycle: the row update and its check are applied before the EOF row check.
- A pixel is accepted in the cycle of EOF only if href is still high. It is still written.

Other rules:
- cap_req held high re-arms immediately after DONE. This gives back-to-back frames, with at least one IDLE cycle between them.
- wr_en is never asserted outside CAPTURE, except for the single registered write that follows the last CAPTURE cycle.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_WAIT_SOF=2'd1, ST_CAPTURE=2'd2, ST_DONE=2'd3;
  - default IMG_W/IMG_H/ADDR_W values, shared with the frame-buffer and recognition blocks.
- One natural sub-module, sync_edge_det, shared with other stream blocks. Per signal it provides a registered copy plus rise and fall pulses; instantiated for vsync and href.
- Counters and FSM stay in the top module.

Test Plan:
All scenarios use IMG_W=4, IMG_H=3.
1. cap_req in vertical blanking; then a 3x4 frame with clken=1, grey values 0..11 -> wr_addr 0..11 with wr_data 0..11; one cap_done pulse one cycle after the EOF-sampled cycle; frame_err=0.
2. cap_req asserted mid-frame (row 1) -> no writes in that frame; the next full frame is captured at addresses 0..11.
3. One line with 5 pixels -> 5th pixel not written; 12 writes total; frame_err=1 at cap_done.
4. Frame with only 2 lines -> 8 writes; frame_err=1 at cap_done.
5. cap_abort after 6 writes -> state IDLE, cap_busy=0, no cap_done, no further writes. A new cap_req then captures a clean frame with frame_err=0.
6. Reset asserted mid-CAPTURE -> wr_en, cap_busy, cap_done and frame_err all 0 immediately (asynchronous). After release, no writes until cap_req and SOF.
